// File: rtl/conv_kxk_mac_seq_if.sv
// conv_kxk_mac_seq_if: window/kernel in, result out handshake bundle.
// master = window source + result sink, slave = the conv engine.
interface conv_kxk_mac_seq_if #(
  parameter int DATA_W = 8,
  parameter int K      = 5,
  parameter int OUT_W  = 2*DATA_W+$clog2(K*K)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [K*K*DATA_W-1:0]   in_data;
  logic [K*K*DATA_W-1:0]   in_kernel;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic                    busy;

  modport master (
    output in_valid, in_data, in_kernel, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_kernel, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/conv_kxk_mac_seq.sv
// conv_kxk_mac_seq: time-multiplexed KxK signed dot product, LANES/cycle.
// Optional ReLU clamp on the result: define CONV_KXK_RELU_EN.
module conv_kxk_mac_seq #(
  parameter int DATA_W = 8,
  parameter int K      = 5,
  parameter int LANES  = 5,
  parameter int OUT_W  = 2*DATA_W+$clog2(K*K)
) (
  input logic               clk,
  input logic               rst_n,
  conv_kxk_mac_seq_if.slave bus
);

  localparam int N  = K*K;
  localparam int G  = (N+LANES-1)/LANES;
  localparam int P  = G*LANES;
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam int IW = (P > 1) ? $clog2(P) : 1;

  if (LANES < 1 || LANES > N || OUT_W < 2*DATA_W) begin : g_bad_cfg
    $error("conv_kxk_mac_seq: bad LANES/OUT_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N*DATA_W-1:0]       win_q;
  logic [N*DATA_W-1:0]       ker_q;
  logic signed [OUT_W-1:0]   acc;
  logic signed [OUT_W-1:0]   gsum;
  logic signed [OUT_W-1:0]   total;
  logic signed [OUT_W-1:0]   final_v;
  logic signed [OUT_W-1:0]   res;
  logic [GW-1:0]             grp;
  logic                      last;
  logic [IW-1:0]             idx;
  logic signed [2*DATA_W-1:0] prod;

  logic signed [DATA_W-1:0]  dpad [P];
  logic signed [DATA_W-1:0]  kpad [P];

  // Zero-pad the window so the last group reads harmless zeros.
  for (genvar i = 0; i < P; i++) begin : g_pad
    if (i < N) begin : g_real
      assign dpad[i] = win_q[i*DATA_W +: DATA_W];
      assign kpad[i] = ker_q[i*DATA_W +: DATA_W];
    end else begin : g_zero
      assign dpad[i] = '0;
      assign kpad[i] = '0;
    end
  end

  // Sum of this group's LANES sign-extended products.
  always_comb begin
    gsum = '0;
    idx  = '0;
    prod = '0;
    for (int l = 0; l < LANES; l++) begin
      idx  = IW'(int'(grp)*LANES + l);
      prod = dpad[idx] * kpad[idx];
      gsum = gsum + OUT_W'(prod);
    end
  end

  assign total = acc + gsum;
  assign last  = (grp == GW'(G-1));

  // Result seen downstream: raw or clamped at zero.
`ifdef CONV_KXK_RELU_EN
  assign final_v = (total < 0) ? '0 : total;
`else
  assign final_v = total;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state selection.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid)  state_nx = ACC;
      ACC:  if (last)          state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  // Capture, accumulate and register the final result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      ker_q <= '0;
      acc   <= '0;
      grp   <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            win_q <= bus.in_data;
            ker_q <= bus.in_kernel;
            acc   <= '0;
            grp   <= '0;
          end
        end
        ACC: begin
          acc <= total;
          grp <= grp + GW'(1);
          if (last) res <= final_v;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_data  = res;

endmodule

// File: tb/tb_conv_kxk_mac_seq.sv
// tb_conv_kxk_mac_seq: randomized bench, dot-product reference model.
// Covers latency, hold, reset, padding (LANES=4) and back-to-back rate.
module tb_conv_kxk_mac_seq;

  localparam int DW = 8;
  localparam int K  = 5;
  localparam int N  = K*K;
  localparam int OW = 2*DW+$clog2(N);
  localparam int G  = 5;
  localparam int G4 = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  conv_kxk_mac_seq_if #(.DATA_W(DW), .K(K), .OUT_W(OW)) ifc ();
  conv_kxk_mac_seq_if #(.DATA_W(DW), .K(K), .OUT_W(OW)) ifc4 ();

  conv_kxk_mac_seq #(
    .DATA_W(DW), .K(K), .LANES(5), .OUT_W(OW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(ifc)
  );

  conv_kxk_mac_seq #(
    .DATA_W(DW), .K(K), .LANES(4), .OUT_W(OW)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(ifc4)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int xfers = 0;
  int acc_q [$];

  always @(posedge clk) begin
    cyc++;
    if (ifc.out_valid && ifc.out_ready) xfers++;
    if (ifc.in_valid && ifc.in_ready) acc_q.push_back(cyc);
  end

  function automatic logic [OW-1:0] model(int d[N], int k[N]);
    longint s = 0;
    for (int i = 0; i < N; i++) s += d[i] * k[i];
`ifdef CONV_KXK_RELU_EN
    if (s < 0) s = 0;
`endif
    return OW'(s);
  endfunction

  task automatic scramble();
    for (int i = 0; i < N; i++) begin
      ifc.in_data[i*DW +: DW]   = DW'($urandom);
      ifc.in_kernel[i*DW +: DW] = DW'($urandom);
    end
  endtask

  task automatic accept(int d[N], int k[N]);
    int t;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ifc.in_data[i*DW +: DW]   = DW'(d[i]);
      ifc.in_kernel[i*DW +: DW] = DW'(k[i]);
    end
    ifc.in_valid = 1'b1;
    t = 0;
    while (!ifc.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!ifc.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (ifc.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_in_ready: got %b want 1", ifc.in_ready);
    end
    n_cmp++;
    if (ifc.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_out_valid: got %b want 0", ifc.out_valid);
    end
    n_cmp++;
    if (ifc.out_data !== '0) begin
      n_bad++; $display("FAIL rst_out_data: got %h want 0", ifc.out_data);
    end
    n_cmp++;
    if (ifc.busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_busy: got %b want 0", ifc.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ones();
    int d[N];
    int k[N];
    int lat;
    for (int i = 0; i < N; i++) begin d[i] = 1; k[i] = 1; end
    ifc.out_ready = 1'b1;
    accept(d, k);
    n_cmp++;
    if (ifc.busy !== 1'b1) begin
      n_bad++; $display("FAIL ones_busy: got %b want 1", ifc.busy);
    end
    wait_out(lat);
    n_cmp++;
    if (lat != G+1) begin
      n_bad++; $display("FAIL ones_latency: got %0d want %0d", lat, G+1);
    end
    n_cmp++;
    if (ifc.out_data !== OW'(25)) begin
      n_bad++; $display("FAIL ones_data: got %0d want 25", ifc.out_data);
    end
    n_cmp++;
    if (ifc.in_ready !== 1'b0) begin
      n_bad++; $display("FAIL ones_ready_done: got %b want 0", ifc.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ones_release: got v=%b r=%b want v=0 r=1",
               ifc.out_valid, ifc.in_ready);
    end
    n_cmp++;
    if (ifc.out_data !== model(d, k)) begin
      n_bad++; $display("FAIL ones_retain: got %0d want %0d",
                        ifc.out_data, model(d, k));
    end
  endtask

  task automatic test_neg128();
    int d[N];
    int k[N];
    int lat;
    for (int i = 0; i < N; i++) begin d[i] = -128; k[i] = -128; end
    ifc.out_ready = 1'b1;
    accept(d, k);
    wait_out(lat);
    n_cmp++;
    if (ifc.out_data !== OW'(409600)) begin
      n_bad++; $display("FAIL neg128_data: got %h want 64000", ifc.out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_hold();
    int d[N];
    int k[N];
    int lat;
    int x0;
    logic [OW-1:0] exp;
    for (int i = 0; i < N; i++) begin d[i] = i; k[i] = 1; end
    exp = model(d, k);
    ifc.out_ready = 1'b0;
    accept(d, k);
    wait_out(lat);
    x0 = xfers;
    for (int c = 0; c < 10; c++) begin
      n_cmp++;
      if (ifc.out_valid !== 1'b1 || ifc.out_data !== exp
          || ifc.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_c%0d: got v=%b d=%0d r=%b want 1/%0d/0",
                 c, ifc.out_valid, ifc.out_data, ifc.in_ready, exp);
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (ifc.out_data !== OW'(300)) begin
      n_bad++; $display("FAIL hold_data: got %0d want 300", ifc.out_data);
    end
    @(negedge clk);
    ifc.out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (ifc.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL hold_drop: got %b want 0", ifc.out_valid);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (xfers - x0 != 1) begin
      n_bad++; $display("FAIL hold_xfers: got %0d want 1", xfers - x0);
    end
  endtask

  task automatic test_lanes4();
    int d[N];
    int k[N];
    int lat;
    int t;
    for (int i = 0; i < N; i++) begin d[i] = i+1; k[i] = 2; end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ifc4.in_data[i*DW +: DW]   = DW'(d[i]);
      ifc4.in_kernel[i*DW +: DW] = DW'(k[i]);
    end
    ifc4.in_valid = 1'b1;
    t = 0;
    while (!ifc4.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    ifc4.in_valid = 1'b0;
    ifc4.in_data  = '0;
    lat = 1;
    while (!ifc4.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat != G4+1) begin
      n_bad++; $display("FAIL l4_latency: got %0d want %0d", lat, G4+1);
    end
    n_cmp++;
    if (ifc4.out_data !== model(d, k)) begin
      n_bad++; $display("FAIL l4_data: got %0d want %0d",
                        ifc4.out_data, model(d, k));
    end
    n_cmp++;
    if (ifc4.out_data !== OW'(650)) begin
      n_bad++; $display("FAIL l4_const: got %0d want 650", ifc4.out_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int d[N];
    int k[N];
    int lat;
    for (int i = 0; i < N; i++) begin
      d[i] = int'($urandom_range(255)) - 128;
      k[i] = int'($urandom_range(255)) - 128;
    end
    ifc.out_ready = 1'b1;
    accept(d, k);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b1
        || ifc.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_outs: got v=%b r=%b b=%b want 0/1/0",
               ifc.out_valid, ifc.in_ready, ifc.busy);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin d[i] = 1; k[i] = 1; end
    accept(d, k);
    wait_out(lat);
    n_cmp++;
    if (lat != G+1 || ifc.out_data !== OW'(25)) begin
      n_bad++;
      $display("FAIL midrst_after: got lat=%0d d=%0d want %0d/25",
               lat, ifc.out_data, G+1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_relu();
    int d[N];
    int k[N];
    int lat;
    logic [OW-1:0] exp;
`ifdef CONV_KXK_RELU_EN
    exp = '0;
`else
    exp = 21'h1FFFE7;
`endif
    for (int i = 0; i < N; i++) begin d[i] = 1; k[i] = -1; end
    ifc.out_ready = 1'b1;
    accept(d, k);
    wait_out(lat);
    n_cmp++;
    if (ifc.out_data !== exp) begin
      n_bad++; $display("FAIL relu_data: got %h want %h", ifc.out_data, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int d[N];
    int k[N];
    int lat;
    int dly;
    logic [OW-1:0] exp;
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < N; i++) begin
        d[i] = int'($urandom_range(255)) - 128;
        k[i] = int'($urandom_range(255)) - 128;
        if (n == 0) begin d[i] = 127; k[i] = -128; end
        if (n == 1) begin d[i] = 127; k[i] = 127; end
      end
      exp = model(d, k);
      dly = int'($urandom_range(3));
      ifc.out_ready = (dly == 0);
      accept(d, k);
      wait_out(lat);
      n_cmp++;
      if (lat != G+1 || ifc.out_data !== exp) begin
        n_bad++;
        $display("FAIL rand%0d: got lat=%0d d=%h want %0d/%h",
                 n, lat, ifc.out_data, G+1, exp);
      end
      repeat (dly) @(posedge clk);
      #1;
      if (dly != 0) begin
        n_cmp++;
        if (ifc.out_valid !== 1'b1 || ifc.out_data !== exp) begin
          n_bad++;
          $display("FAIL rand%0d_hold: got v=%b d=%h want 1/%h",
                   n, ifc.out_valid, ifc.out_data, exp);
        end
        @(negedge clk);
        ifc.out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    int t;
    int x0;
    acc_q.delete();
    x0 = xfers;
    ifc.out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      ifc.in_data[i*DW +: DW]   = DW'(1);
      ifc.in_kernel[i*DW +: DW] = DW'(1);
    end
    ifc.in_valid = 1'b1;
    t = 0;
    while (acc_q.size() < 3 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    ifc.in_valid = 1'b0;
    repeat (G+4) @(posedge clk);
    #1;
    n_cmp++;
    if (acc_q.size() != 3) begin
      n_bad++; $display("FAIL b2b_count: got %0d want 3", acc_q.size());
    end else begin
      n_cmp++;
      if (acc_q[1]-acc_q[0] != G+2 || acc_q[2]-acc_q[1] != G+2) begin
        n_bad++;
        $display("FAIL b2b_rate: got %0d,%0d want %0d",
                 acc_q[1]-acc_q[0], acc_q[2]-acc_q[1], G+2);
      end
    end
    n_cmp++;
    if (xfers - x0 != 3 || ifc.out_data !== OW'(25)) begin
      n_bad++;
      $display("FAIL b2b_out: got x=%0d d=%0d want 3/25",
               xfers - x0, ifc.out_data);
    end
  endtask

  initial begin
    ifc.in_valid   = 1'b0;
    ifc.in_data    = '0;
    ifc.in_kernel  = '0;
    ifc.out_ready  = 1'b1;
    ifc4.in_valid  = 1'b0;
    ifc4.in_data   = '0;
    ifc4.in_kernel = '0;
    ifc4.out_ready = 1'b1;
    test_reset();
    test_ones();
    test_neg128();
    test_hold();
    test_lanes4();
    test_reset_mid();
    test_relu();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
